// File: rtl/hs_skid_buffer.sv
// hs_skid_buffer: registered valid/ready skid buffer; optional xfer_cnt output via HS_SKID_XFER_CNT_EN
module hs_skid_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
`ifdef HS_SKID_XFER_CNT_EN
    output logic [31:0]       xfer_cnt,
`endif
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              m_valid_q, s_ready_q;
    logic              up, dn;

    assign up      = s_valid & s_ready_q;
    assign dn      = m_valid_q & m_ready;
    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = main_q;

    // Next state and register loads; the skid beat always drains into main before newer data
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (up) begin
                main_d  = s_data;
                state_d = BUSY;
            end
            BUSY: begin
                if (up && dn) main_d = s_data;
                else if (up) begin
                    skid_d  = s_data;
                    state_d = FULL;
                end else if (dn) state_d = EMPTY;
            end
            FULL: if (dn) begin
                main_d  = skid_q;
                state_d = BUSY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and datapath flops; valid/ready are registered copies of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            m_valid_q <= state_d != EMPTY;
            s_ready_q <= state_d != FULL;
        end
    end

`ifdef HS_SKID_XFER_CNT_EN
    logic [31:0] xfer_cnt_q;

    assign xfer_cnt = xfer_cnt_q;

    // Count completed downstream transfers, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) xfer_cnt_q <= '0;
        else if (dn) xfer_cnt_q <= xfer_cnt_q + 32'd1;
    end
`endif
endmodule

// File: doc/hs_skid_buffer.md
Name: hs_skid_buffer

Overview:
- Registered valid/ready pipeline stage (skid buffer) inserted between a data master and a slave on the 32-bit valid/ready handshake link.
- Breaks the combinational ready path upstream and the valid/data path downstream.
- Sustains one transfer per clock and preserves order.
- Upstream side faces the master; downstream side faces the slave.

Parameters:
- DATA_W, 32, payload width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- s_data  input  DATA_W  upstream payload
- s_valid  input  1  upstream valid
- s_ready  output  1  upstream ready, driven directly from a flop
- m_data  output  DATA_W  downstream payload, driven directly from a flop
- m_valid  output  1  downstream valid, driven directly from a flop
- m_ready  input  1  downstream ready
- xfer_cnt  output  32  completed downstream transfers; present only with HS_SKID_XFER_CNT_EN

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst; all flops clear immediately when rst rises, independent of clk.
- Reset values:
  - m_valid=0, m_data=0, s_ready=0.
  - Skid register valid=0, skid data=0.
  - State=EMPTY.
- s_ready rises to 1 on the first rising clk edge after rst deasserts.
- Handshakes:
  - Upstream transfer occurs when s_valid&s_ready at a rising edge.
  - Downstream transfer occurs when m_valid&m_ready at a rising edge.
- Storage is two registers: main (drives m_data/m_valid) and skid.
- State machine:
  - EMPTY: m_valid=0, s_ready=1.
    - If upstream transfer: main<=s_data, m_valid<=1, go BUSY.
  - BUSY: m_valid=1, s_ready=1.
    - Upstream and downstream transfer together: main<=s_data, stay BUSY.
    - Upstream only: skid<=s_data, s_ready<=0, go FULL.
    - Downstream only: m_valid<=0, go EMPTY.
    - Neither: hold.
  - FULL: m_valid=1, s_ready=0.
    - If downstream transfer: main<=skid, s_ready<=1, go BUSY.
    - Otherwise hold.
    - s_valid is ignored in FULL.
- Latency: data accepted at edge N appears on m_data with m_valid=1 after edge N (one cycle) when the block was EMPTY or BUSY-with-drain.
- Throughput: with m_ready held 1, one beat per cycle indefinitely; s_ready never drops.
- Stability rules:
  - While m_valid=1 and m_ready=0, m_data and m_valid are held constant.
  - s_ready changes only on clock edges.
- Ordering: strict FIFO. The skid beat is always older than any later upstream beat.
- No combinational path from m_ready to s_ready, or from s_valid/s_data to m_valid/m_data.
- Maximum occupancy is 2 beats. No data is dropped or duplicated under any s_valid/m_ready pattern.
- Reset mid-operation: both stored beats are discarded, outputs return to reset values asynchronously, and restart follows the post-reset rule above.

Optional Feature:
- Macro: HS_SKID_XFER_CNT_EN.
- Defined:
  - Adds output xfer_cnt[31:0], reset to 0.
  - Increments by 1 on every downstream transfer.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared asynchronously by rst.
- Undefined: xfer_cnt port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 3 cycles with s_valid=1 -> m_valid=0 and s_ready=0 throughout; s_ready=1 one edge after rst falls; no beat accepted during reset.
- Single beat: s_data=0xA5A5_0001, s_valid=1 for one accepted cycle, m_ready=1 -> m_valid=1 with m_data=0xA5A5_0001 for exactly one cycle, one cycle after acceptance; then EMPTY.
- Streaming: 16 consecutive beats 0x0..0xF with m_ready=1 -> s_ready stays 1; m_data outputs 0x0..0xF in order on consecutive cycles.
- Backpressure: send 0x11, 0x22, 0x33 back-to-back while m_ready=0 -> 0x11 held on m_data, 0x22 captured in skid, s_ready=0 so 0x33 is stalled. Raise m_ready -> outputs 0x11, 0x22, 0x33 in order with no loss.
- Reset mid-operation: reach FULL holding 0x44/0x55, pulse rst asynchronously between clock edges -> m_valid drops immediately; after release, only new beats appear and 0x44/0x55 are never output.
- With HS_SKID_XFER_CNT_EN: preload the counter via 0xFFFFFFFE forced transfers (or force the counter), then perform 3 transfers -> xfer_cnt reads 0xFFFFFFFF, 0x0, 0x1; after rst, xfer_cnt=0.
